// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: registered state, outputs decoded from state.
// Optional `IMM_LOGIC_EN adds andi/ori execute states.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] ALUOp,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_ANDIEX = 4'd12,
    S_ORIEX  = 4'd13,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_ok;
  logic [3:0] w_funct_alu;

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = ALU_ADD;
    case (funct)
      6'h20:   w_funct_alu = ALU_ADD;
      6'h22:   w_funct_alu = ALU_SUB;
      6'h24:   w_funct_alu = ALU_AND;
      6'h25:   w_funct_alu = ALU_OR;
      6'h27:   w_funct_alu = ALU_NOR;
      6'h2A:   w_funct_alu = ALU_SLT;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h23, 6'h2B: w_next = S_MEMADR;
          6'h00:        w_next = S_EXEC;
          6'h04:        w_next = S_BRANCH;
          6'h08:        w_next = S_ADDIEX;
          6'h02:        w_next = S_JUMP;
`ifdef IMM_LOGIC_EN
          6'h0C:        w_next = S_ANDIEX;
          6'h0D:        w_next = S_ORIEX;
`endif
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = w_funct_ok ? S_ALUWB : S_TRAP;
      S_ADDIEX: w_next = S_IMMWB;
`ifdef IMM_LOGIC_EN
      S_ANDIEX: w_next = S_IMMWB;
      S_ORIEX:  w_next = S_IMMWB;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    ALUOp      = ALU_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        ALUOp     = w_funct_alu;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUOp     = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_IMMWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef IMM_LOGIC_EN
      S_ANDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUOp     = ALU_AND;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUOp     = ALU_OR;
      end
`endif
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    // Reset holds FETCH muxing but must not let any enable escape
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-cycle expected
// output vectors are queued by stimulus and checked at each falling edge.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [3:0] ALUOp;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       i_or_d, alu_src_a, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       illegal;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic [4:0] en;   // pc_write ir_write mem_read mem_write reg_write
    logic [3:0] sel;  // i_or_d alu_src_a reg_dst mem_to_reg
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       ill;
  } ev_t;

  typedef struct {
    ev_t   e;
    string nm;
  } item_t;

  localparam ev_t RST = '{4'd0, 4'b0010, 5'b00000, 4'b0000, 2'b01, 2'b00, 1'b0};
  localparam ev_t FE  = '{4'd0, 4'b0010, 5'b11100, 4'b0000, 2'b01, 2'b00, 1'b0};
  localparam ev_t DE  = '{4'd1, 4'b0010, 5'b00000, 4'b0000, 2'b11, 2'b00, 1'b0};
  localparam ev_t MA  = '{4'd2, 4'b0010, 5'b00000, 4'b0100, 2'b10, 2'b00, 1'b0};
  localparam ev_t MR  = '{4'd3, 4'b0010, 5'b00100, 4'b1000, 2'b00, 2'b00, 1'b0};
  localparam ev_t MWB = '{4'd4, 4'b0010, 5'b00001, 4'b0001, 2'b00, 2'b00, 1'b0};
  localparam ev_t MW  = '{4'd5, 4'b0010, 5'b00010, 4'b1000, 2'b00, 2'b00, 1'b0};
  localparam ev_t AWB = '{4'd7, 4'b0010, 5'b00001, 4'b0010, 2'b00, 2'b00, 1'b0};
  localparam ev_t BRT = '{4'd8, 4'b0110, 5'b10000, 4'b0100, 2'b00, 2'b01, 1'b0};
  localparam ev_t BRN = '{4'd8, 4'b0110, 5'b00000, 4'b0100, 2'b00, 2'b01, 1'b0};
  localparam ev_t AIX = '{4'd9, 4'b0010, 5'b00000, 4'b0100, 2'b10, 2'b00, 1'b0};
  localparam ev_t IWB = '{4'd10, 4'b0010, 5'b00001, 4'b0000, 2'b00, 2'b00, 1'b0};
  localparam ev_t JMP = '{4'd11, 4'b0010, 5'b10000, 4'b0000, 2'b00, 2'b10, 1'b0};
  localparam ev_t ANX = '{4'd12, 4'b0000, 5'b00000, 4'b0100, 2'b10, 2'b00, 1'b0};
  localparam ev_t ORX = '{4'd13, 4'b0001, 5'b00000, 4'b0100, 2'b10, 2'b00, 1'b0};
  localparam ev_t TRP = '{4'd15, 4'b0010, 5'b00000, 4'b0000, 2'b00, 2'b00, 1'b1};

  item_t q[$];
  int    checks   = 0;
  int    failures = 0;
  ev_t   w_act;

  mips_multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .ALUOp      (ALUOp),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .i_or_d     (i_or_d),
    .alu_src_a  (alu_src_a),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign w_act = '{state, ALUOp,
                   {pc_write, ir_write, mem_read, mem_write, reg_write},
                   {i_or_d, alu_src_a, reg_dst, mem_to_reg},
                   alu_src_b, pc_source, illegal};

  // Monitor: one expected vector consumed per cycle, mid-cycle
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        it = q.pop_front();
        checks++;
        if (w_act !== it.e) begin
          failures++;
          $display("FAIL %s: got %h required %h", it.nm, w_act, it.e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic push(input ev_t e, input string nm);
    item_t it;
    it.e  = e;
    it.nm = nm;
    q.push_back(it);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    push(RST, "reset_outs");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input string nm);
    opcode = op;
    funct  = fn;
    zero   = z;
    push(FE, {nm, "_fetch"});
    push(DE, {nm, "_decode"});
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [3:0] alu,
                       input string nm);
    ev_t ex;
    ex = '{4'd6, alu, 5'b00000, 4'b0100, 2'b00, 2'b00, 1'b0};
    start(6'h00, fn, 1'b0, nm);
    push(ex, {nm, "_exec"});
    push(AWB, {nm, "_aluwb"});
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;
    hold_reset();

    rtype(6'h27, 4'b1100, "nor");
    rtype(6'h20, 4'b0010, "add");
    rtype(6'h22, 4'b0110, "sub");
    rtype(6'h24, 4'b0000, "and");
    rtype(6'h25, 4'b0001, "or");
    rtype(6'h2A, 4'b0111, "slt");

    start(6'h23, 6'h00, 1'b0, "lw");
    push(MA, "lw_memadr");
    push(MR, "lw_memrd");
    push(MWB, "lw_memwb");
    repeat (5) @(posedge clk);
    #1;

    start(6'h2B, 6'h00, 1'b0, "sw");
    push(MA, "sw_memadr");
    push(MW, "sw_memwr");
    repeat (4) @(posedge clk);
    #1;

    start(6'h08, 6'h00, 1'b0, "addi");
    push(AIX, "addi_ex");
    push(IWB, "addi_wb");
    repeat (4) @(posedge clk);
    #1;

    start(6'h04, 6'h00, 1'b1, "beq_t");
    push(BRT, "beq_taken");
    repeat (3) @(posedge clk);
    #1;

    start(6'h04, 6'h00, 1'b0, "beq_n");
    push(BRN, "beq_not");
    repeat (3) @(posedge clk);
    #1;

    start(6'h02, 6'h00, 1'b0, "j");
    push(JMP, "j_jump");
    repeat (3) @(posedge clk);
    #1;

    start(6'h3F, 6'h00, 1'b0, "op3f");
    push(TRP, "op3f_trap");
    push(FE, "op3f_after");
    repeat (3) @(posedge clk);
    #1;
    q.delete(q.size() - 1);
    @(negedge clk);
    #1;
    repeat (1) @(posedge clk);
    #1;
    hold_reset();

    start(6'h00, 6'h03, 1'b0, "fn03");
    push('{4'd6, 4'b0010, 5'b00000, 4'b0100, 2'b00, 2'b00, 1'b0},
         "fn03_exec");
    push(TRP, "fn03_trap");
    repeat (4) @(posedge clk);
    #1;

`ifdef IMM_LOGIC_EN
    start(6'h0D, 6'h00, 1'b0, "ori");
    push(ORX, "ori_ex");
    push(IWB, "ori_wb");
    repeat (4) @(posedge clk);
    #1;
    start(6'h0C, 6'h00, 1'b0, "andi");
    push(ANX, "andi_ex");
    push(IWB, "andi_wb");
    repeat (4) @(posedge clk);
    #1;
`else
    start(6'h0D, 6'h00, 1'b0, "ori");
    push(TRP, "ori_trap");
    repeat (3) @(posedge clk);
    #1;
    start(6'h0C, 6'h00, 1'b0, "andi");
    push(TRP, "andi_trap");
    repeat (3) @(posedge clk);
    #1;
`endif

    // Abandon a load mid-MEMRD with an asynchronous reset pulse
    start(6'h23, 6'h00, 1'b0, "lwrst");
    push(MA, "lwrst_memadr");
    push(MR, "lwrst_memrd");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || reg_write !== 1'b0 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got state=%0d rw=%b mr=%b required 0 0 0",
               state, reg_write, mem_read);
    end
    hold_reset();

    start(6'h00, 6'h20, 1'b0, "post");
    push('{4'd6, 4'b0010, 5'b00000, 4'b0100, 2'b00, 2'b00, 1'b0},
         "post_exec");
    push(AWB, "post_aluwb");
    repeat (4) @(posedge clk);
    #1;

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  IR[31:26]; stable from DECODE until the instruction retires.
REQ-005 funct  in  6  IR[5:0]; same stability as opcode.
REQ-006 zero  in  1  ALU zero flag (result == 0), same cycle.
REQ-007 ALUOp  out  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-008 pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  write/read enables.
REQ-009 i_or_d, alu_src_a, reg_dst, mem_to_reg  out  1 each  datapath mux selects.
REQ-010 alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-011 pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
REQ-013 state  out  4  current state code, for debug.

Function
REQ-014 Moore FSM with one registered 4-bit state; outputs are decoded combinationally from state, plus funct in EXEC and zero in BRANCH.
REQ-015 Unlisted outputs are 0 in each state; ALUOp defaults to 0010.
REQ-016 FETCH(0): mem_read, ir_write, pc_write=1; alu_src_b=01; ALUOp=ADD; next DECODE.
REQ-017 DECODE(1): alu_src_b=11; ALUOp=ADD (branch target). Next state by opcode: 0x23/0x2B MEMADR, 0x00 EXEC, 0x04 BRANCH, 0x08 ADDIEX, 0x02 JUMP, otherwise TRAP.
REQ-018 MEMADR(2): alu_src_a=1, alu_src_b=10, ADD. Next MEMRD for 0x23, MEMWR for 0x2B.
REQ-019 MEMRD(3): mem_read=1, i_or_d=1; next MEMWB.
REQ-020 MEMWB(4): reg_write=1, mem_to_reg=1; next FETCH.
REQ-021 MEMWR(5): mem_write=1, i_or_d=1; next FETCH.
REQ-022 EXEC(6): alu_src_a=1, alu_src_b=00. funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT; next ALUWB. Any other funct goes to TRAP.
REQ-023 ALUWB(7): reg_write=1, reg_dst=1; next FETCH.
REQ-024 BRANCH(8): alu_src_a=1, SUB, pc_source=01, pc_write=zero; next FETCH.
REQ-025 ADDIEX(9): alu_src_a=1, alu_src_b=10, ADD; next IMMWB.
REQ-026 IMMWB(10): reg_write=1 (reg_dst=0, mem_to_reg=0); next FETCH.
REQ-027 JUMP(11): pc_write=1, pc_source=10; next FETCH.
REQ-028 TRAP(15): illegal=1, no writes; next FETCH.
REQ-029 Latency in cycles: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3, trap 3.
REQ-030 Unused state codes go to FETCH on the next edge with no writes.

Reset
REQ-031 Asserting reset forces state to FETCH immediately, including mid-instruction; any partially executed instruction is abandoned.
REQ-032 While reset is high, pc_write, ir_write, mem_read, mem_write, reg_write and illegal are 0; other outputs take their FETCH values.
REQ-033 After reset deasserts, the first rising edge is a normal FETCH cycle.

Configuration
REQ-034 Macro IMM_LOGIC_EN, when defined: DECODE sends 0x0C to ANDIEX(12) (AND, alu_src_b=10) and 0x0D to ORIEX(13) (OR, alu_src_b=10); both next IMMWB; andi/ori take 4 cycles.
REQ-035 Without IMM_LOGIC_EN: 0x0C/0x0D go to TRAP, and states 12/13 are treated as unused.

Verification
REQ-036 Reset pulse mid-MEMRD -> state=0 asynchronously; all enables 0 while reset is high; FETCH outputs on the first edge after release.
REQ-037 opcode 0x00, funct 0x27 -> states 0,1,6,7; ALUOp=1100 in EXEC; reg_write=1 and reg_dst=1 in ALUWB.
REQ-038 lw (0x23) -> states 0,1,2,3,4; i_or_d=1 in MEMRD; reg_write=1 and mem_to_reg=1 in MEMWB.
REQ-039 beq (0x04) with zero=1, then zero=0 -> BRANCH pc_write=1 with pc_source=01, then pc_write=0; ALUOp=0110.
REQ-040 opcode 0x3F, and R-type funct 0x03 -> TRAP reached, illegal pulses exactly 1 cycle, no write enables asserted.
REQ-041 opcode 0x0D -> with IMM_LOGIC_EN: states 0,1,13,10 and ALUOp=0001; without it: TRAP.
